// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch and data ports:
// data-first priority with a starvation guard, byte masks and tagged read returns.
module sram_arbiter #(
    parameter int AW           = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          im_req,
    input  logic [31:0]   im_addr,
    output logic          im_gnt,
    output logic          im_rvalid,
    output logic [31:0]   im_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,
    output logic          sram_ceb,
    output logic          sram_web,
    output logic [31:0]   sram_bweb,
    output logic [AW-1:0] sram_a,
    output logic [31:0]   sram_di,
    input  logic [31:0]   sram_do
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_IM   = 2'b01,
        SRC_DM   = 2'b10
    } src_e;

    // Active-high byte enables to the macro's active-low bit mask.
    function automatic logic [31:0] be_to_bweb(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{~be[i]}};
        end
        return mask;
    endfunction

    logic [CW-1:0] starve_cnt_r;
    src_e          rd_src_r;
    logic          err_r;
    logic [AW-1:0] a_r;
    logic [31:0]   di_r;

    logic im_win_s;
    logic dm_win_s;
    logic dm_oor_s;
    logic dm_acc_s;
    logic dm_wr_s;
    logic dm_rd_s;
    logic unused_s;

    assign unused_s = ^{im_addr[31:AW+2], im_addr[1:0], dm_addr[1:0]};

    // Arbitration: data wins ties unless the instruction port has waited STARVE_LIMIT grants.
    always_comb begin
        im_win_s = 1'b0;
        dm_win_s = 1'b0;
        if (!rst) begin
            im_win_s = 1'b0;
            dm_win_s = 1'b0;
        end else if (im_req && (!dm_req || (starve_cnt_r == LIMIT))) begin
            im_win_s = 1'b1;
        end else if (dm_req) begin
            dm_win_s = 1'b1;
        end else begin
            im_win_s = 1'b0;
            dm_win_s = 1'b0;
        end
        dm_oor_s = |dm_addr[31:AW+2];
        dm_acc_s = dm_win_s && !dm_oor_s;
        dm_wr_s  = dm_acc_s && dm_we;
        dm_rd_s  = dm_acc_s && !dm_we;
    end

    // SRAM command; address and write data fall back to their shadows when idle.
    always_comb begin
        im_gnt    = im_win_s;
        dm_gnt    = dm_win_s;
        sram_ceb  = !(im_win_s || dm_acc_s);
        sram_web  = !dm_wr_s;
        sram_bweb = 32'hFFFF_FFFF;
        sram_a    = a_r;
        sram_di   = di_r;
        if (dm_wr_s) begin
            sram_bweb = be_to_bweb(dm_be);
            sram_di   = dm_wdata;
        end else begin
            sram_bweb = 32'hFFFF_FFFF;
            sram_di   = di_r;
        end
        if (im_win_s) begin
            sram_a = im_addr[AW+1:2];
        end else if (dm_acc_s) begin
            sram_a = dm_addr[AW+1:2];
        end else begin
            sram_a = a_r;
        end
    end

    // Return steering from the read tag and the registered error flag.
    always_comb begin
        im_rvalid = 1'b0;
        im_rdata  = 32'h0000_0000;
        dm_rvalid = err_r;
        dm_rdata  = 32'h0000_0000;
        dm_err    = err_r;
        case (rd_src_r)
            SRC_IM: begin
                im_rvalid = 1'b1;
                im_rdata  = sram_do;
            end
            SRC_DM: begin
                dm_rvalid = 1'b1;
                dm_rdata  = sram_do;
            end
            default: begin
                im_rvalid = 1'b0;
                dm_rvalid = err_r;
            end
        endcase
    end

    // Saturating count of data grants taken while an instruction request waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (im_win_s || !im_req) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (dm_win_s && (starve_cnt_r != LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + CW'(1'b1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Read tag and error flag for the response one cycle after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_src_r <= SRC_NONE;
            err_r    <= 1'b0;
        end else begin
            if (im_win_s) begin
                rd_src_r <= SRC_IM;
            end else if (dm_rd_s) begin
                rd_src_r <= SRC_DM;
            end else begin
                rd_src_r <= SRC_NONE;
            end
            err_r <= dm_win_s && dm_oor_s;
        end
    end

    // Shadow registers keep the address and data buses quiet on idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r  <= {AW{1'b0}};
            di_r <= 32'h0000_0000;
        end else begin
            a_r  <= sram_a;
            di_r <= sram_di;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM and
// hand-computed expected values.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        sram_ceb;
    logic        sram_web;
    logic [31:0] sram_bweb;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    int errors = 0;
    int checks = 0;

    sram_arbiter #(.AW(14), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_gnt    (im_gnt),
        .im_rvalid (im_rvalid),
        .im_rdata  (im_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_bweb (sram_bweb),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: 16 words, preloaded contents until first written.
    function automatic logic [31:0] preload(input logic [3:0] w);
        case (w)
            4'd0:    return 32'h1111_0000;
            4'd1:    return 32'h2222_0001;
            4'd2:    return 32'h3333_0002;
            4'd4:    return 32'h1234_5678;
            4'd8:    return 32'h4444_0008;
            default: return 32'h0000_0000;
        endcase
    endfunction

    logic [31:0] wmem [0:15];
    logic [15:0] wvalid = 16'h0000;
    logic [31:0] cur_word;
    assign cur_word = wvalid[sram_a[3:0]] ? wmem[sram_a[3:0]] : preload(sram_a[3:0]);

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) begin
                wmem[sram_a[3:0]]   <= (cur_word & sram_bweb) | (sram_di & ~sram_bweb);
                wvalid[sram_a[3:0]] <= 1'b1;
            end else begin
                sram_do <= cur_word;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Both ports requesting continuously: dm,dm,dm,dm,im repeating from a cleared counter.
    task automatic run_pattern(input int n);
        logic prev_im;
        logic prev_dm;
        logic exp_im;
        prev_im = 1'b0;
        prev_dm = 1'b0;
        for (int c = 0; c < n; c++) begin
            exp_im = ((c % 5) == 4);
            @(negedge clk);
            check_eq("pat_im_gnt", 32'(im_gnt), 32'(exp_im));
            check_eq("pat_dm_gnt", 32'(dm_gnt), 32'(!exp_im));
            check_eq("pat_im_rvalid", 32'(im_rvalid), 32'(prev_im));
            check_eq("pat_dm_rvalid", 32'(dm_rvalid), 32'(prev_dm));
            if (prev_im) check_eq("pat_im_rdata", im_rdata, 32'h3333_0002);
            if (prev_dm) check_eq("pat_dm_rdata", dm_rdata, 32'h4444_0008);
            prev_im = exp_im;
            prev_dm = !exp_im;
            next_cycle();
        end
    endtask

    logic [31:0] exp_fetch [0:2];

    initial begin
        exp_fetch[0] = 32'h1111_0000;
        exp_fetch[1] = 32'h2222_0001;
        exp_fetch[2] = 32'h3333_0002;

        rst      = 1'b0;
        im_req   = 1'b1;
        im_addr  = 32'h0000_0008;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_be    = 4'hF;
        dm_addr  = 32'h0000_0020;
        dm_wdata = 32'h0000_0000;

        // Reset values with both requests high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_im_gnt", 32'(im_gnt), 32'd0);
        check_eq("rst_dm_gnt", 32'(dm_gnt), 32'd0);
        check_eq("rst_im_rvalid", 32'(im_rvalid), 32'd0);
        check_eq("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
        check_eq("rst_dm_err", 32'(dm_err), 32'd0);
        check_eq("rst_im_rdata", im_rdata, 32'h0000_0000);
        check_eq("rst_dm_rdata", dm_rdata, 32'h0000_0000);
        check_eq("rst_ceb", 32'(sram_ceb), 32'd1);
        check_eq("rst_web", 32'(sram_web), 32'd1);
        check_eq("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
        check_eq("rst_a", 32'(sram_a), 32'd0);
        check_eq("rst_di", sram_di, 32'h0000_0000);

        // Release: dm first, then starvation pattern.
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_pattern(10);

        // im read granted, then reset before the next edge.
        dm_req = 1'b0;
        @(negedge clk);
        check_eq("rsta_im_gnt", 32'(im_gnt), 32'd1);
        #1;
        rst = 1'b0;
        next_cycle();
        rst    = 1'b1;
        im_req = 1'b0;
        @(negedge clk);
        check_eq("rsta_im_rvalid", 32'(im_rvalid), 32'd0);
        check_eq("rsta_dm_rvalid", 32'(dm_rvalid), 32'd0);
        next_cycle();

        // Build up starvation count, reset mid-cycle, counter must restart from zero.
        im_req = 1'b1;
        dm_req = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("rstb_dm_gnt", 32'(dm_gnt), 32'd1);
        #1;
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        run_pattern(5);

        // Partial write then read of the same word.
        im_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 32'h0000_0010;
        dm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("wr_dm_gnt", 32'(dm_gnt), 32'd1);
        check_eq("wr_ceb", 32'(sram_ceb), 32'd0);
        check_eq("wr_web", 32'(sram_web), 32'd0);
        check_eq("wr_bweb", sram_bweb, 32'hFFFF_0000);
        check_eq("wr_a", 32'(sram_a), 32'd4);
        check_eq("wr_di", sram_di, 32'hDEAD_BEEF);
        next_cycle();
        dm_we = 1'b0;
        @(negedge clk);
        check_eq("rd_a", 32'(sram_a), 32'd4);
        check_eq("rd_web", 32'(sram_web), 32'd1);
        check_eq("rd_ceb", 32'(sram_ceb), 32'd0);
        check_eq("rd_bweb", sram_bweb, 32'hFFFF_FFFF);
        check_eq("wr_no_rvalid", 32'(dm_rvalid), 32'd0);
        next_cycle();
        dm_req = 1'b0;
        @(negedge clk);
        check_eq("rd_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check_eq("rd_dm_rdata", dm_rdata, 32'h1234_BEEF);
        check_eq("rd_dm_err", 32'(dm_err), 32'd0);
        check_eq("idle_ceb", 32'(sram_ceb), 32'd1);
        check_eq("idle_a_hold", 32'(sram_a), 32'd4);
        check_eq("idle_di_hold", sram_di, 32'hDEAD_BEEF);
        next_cycle();

        // Write with no byte enables: still issued, mask all ones.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'b0000;
        dm_addr  = 32'h0000_0014;
        dm_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("be0_dm_gnt", 32'(dm_gnt), 32'd1);
        check_eq("be0_web", 32'(sram_web), 32'd0);
        check_eq("be0_bweb", sram_bweb, 32'hFFFF_FFFF);
        next_cycle();

        // Out-of-range data read alongside instruction traffic.
        dm_we   = 1'b0;
        dm_be   = 4'hF;
        dm_addr = 32'h0001_0000;
        im_req  = 1'b1;
        im_addr = 32'h0000_0008;
        @(negedge clk);
        check_eq("oor_dm_gnt", 32'(dm_gnt), 32'd1);
        check_eq("oor_im_gnt", 32'(im_gnt), 32'd0);
        check_eq("oor_ceb", 32'(sram_ceb), 32'd1);
        next_cycle();
        dm_req = 1'b0;
        @(negedge clk);
        check_eq("oor_dm_err", 32'(dm_err), 32'd1);
        check_eq("oor_dm_rvalid", 32'(dm_rvalid), 32'd1);
        check_eq("oor_dm_rdata", dm_rdata, 32'h0000_0000);
        check_eq("oor_im_gnt2", 32'(im_gnt), 32'd1);
        check_eq("oor_im_a", 32'(sram_a), 32'd2);
        next_cycle();
        im_req = 1'b0;
        @(negedge clk);
        check_eq("oor_im_rvalid", 32'(im_rvalid), 32'd1);
        check_eq("oor_im_rdata", im_rdata, 32'h3333_0002);
        check_eq("oor_err_clear", 32'(dm_err), 32'd0);
        next_cycle();

        // Back-to-back instruction fetches.
        im_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            im_addr = 32'(4 * i);
            @(negedge clk);
            check_eq("b2b_im_gnt", 32'(im_gnt), 32'd1);
            check_eq("b2b_a", 32'(sram_a), 32'(i));
            if (i > 0) begin
                check_eq("b2b_rvalid", 32'(im_rvalid), 32'd1);
                check_eq("b2b_rdata", im_rdata, exp_fetch[i-1]);
            end
            next_cycle();
        end
        im_req = 1'b0;
        @(negedge clk);
        check_eq("b2b_rvalid_last", 32'(im_rvalid), 32'd1);
        check_eq("b2b_rdata_last", im_rdata, exp_fetch[2]);
        next_cycle();
        @(negedge clk);
        check_eq("b2b_rvalid_end", 32'(im_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-port SRAM arbiter that shares one `SRAM_wrapper` instance between the CPU instruction-fetch port and the data-memory port. It sits between `cpu` and the memory macro in `top`, and replaces the separate IM/DM macros with one unified memory. It applies fixed data-first priority with an instruction-starvation guard, builds active-low byte write masks, and tags each read so the return data reaches the correct requester.

## Interface
- `AW`, 14: SRAM word-address width. `sram_a` carries `addr[AW+1:2]`.
- `STARVE_LIMIT`, 4: maximum number of consecutive `dm` grants while `im_req` is waiting.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `im_req` in 1, `im_addr` in 32: instruction read request and byte address.
- `im_gnt` out 1: request accepted this cycle.
- `im_rvalid` out 1, `im_rdata` out 32: instruction read return.
- `dm_req` in 1, `dm_we` in 1, `dm_be` in 4, `dm_addr` in 32, `dm_wdata` in 32: data request.
  - `dm_we`=1 is a write.
  - `dm_be` is the active-high byte enable.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1, `dm_rdata` out 32, `dm_err` out 1: data read return or error response.
- `sram_ceb`, `sram_web` out 1: active-low chip enable and write enable.
- `sram_bweb` out 32: active-low bit write mask.
- `sram_a` out AW: word address.
- `sram_di` out 32: write data.
- `sram_do` in 32: read data, valid one cycle after a read is issued.

## Operation
- At most one SRAM access is issued per cycle.
- Grants are combinational (Mealy) in the request cycle. The SRAM samples its inputs on the following rising edge.
- Requesters hold `req`, `addr`, `we`, `be` and `wdata` stable until they see `gnt`.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, `dm` wins, unless `starve_cnt == STARVE_LIMIT`, in which case `im` wins.
- `starve_cnt` (registered, saturating):
  - increments on a `dm` grant while `im_req`=1;
  - clears on an `im` grant or when `im_req`=0.
- Out-of-range data address (`dm_addr[31:AW+2]` ≠ 0):
  - `dm_gnt`=1 and no SRAM access is made (`sram_ceb`=1);
  - next cycle `dm_rvalid`=1, `dm_err`=1, `dm_rdata`=0;
  - applies to both reads and writes;
  - still counts as a `dm` grant for arbitration and for `starve_cnt`.
- Instruction addresses are never range-checked.
- Read issue:
  - `sram_ceb`=0, `sram_web`=1, `sram_bweb`=all ones;
  - tag register `rd_src` ← IM or DM.
- Write issue:
  - `sram_ceb`=0, `sram_web`=0, `sram_di`=`dm_wdata`;
  - `sram_bweb[8i+7:8i]` = {8{~`dm_be[i]`}};
  - `rd_src` ← NONE.
  - No return pulse is produced for an in-range write.
  - A write with `dm_be`=0 is still granted and issued with bweb all ones, so no bits change.
- No grant: `sram_ceb`=1, `sram_web`=1, bweb all ones. `sram_a` and `sram_di` hold their previous values (registered shadow), so idle cycles do not toggle them.
- Return path:
  - `im_rvalid` = (`rd_src`==IM); `dm_rvalid` = (`rd_src`==DM) or the registered error flag.
  - `rdata` = `sram_do` when that port's `rvalid` is set, else 0.
- A write followed by a read of the same word returns the new data, since the SRAM ordering is preserved.
- Reset (`rst`=0):
  - `rd_src`=NONE, `starve_cnt`=0, error flag=0;
  - all `gnt`, `rvalid` and `err` outputs = 0; `rdata`=0;
  - `sram_ceb`=1, `sram_web`=1, `sram_bweb`=32'hFFFF_FFFF, `sram_a`=0, `sram_di`=0.
- Reset mid-access: any pending return is discarded; no `rvalid` appears after release.

## Timing
- Grant latency: 0 cycles (same cycle as `req`, when the port wins).
- Read data: `rvalid` exactly 1 cycle after the granting cycle, lasting 1 cycle.
- Error response: also exactly 1 cycle after grant.
- Throughput: one access per cycle, back-to-back, including read→write and write→read with no bubble.
- Worst-case `im` wait under continuous `dm` traffic: STARVE_LIMIT cycles, then one `im` grant.
- First grant is possible in the first cycle after `rst` deasserts.

## Test plan
- Reset with all requests high → all outputs at their reset values. First edge after release: `dm` is granted and `im_gnt`=0.
- `dm` write 0xDEADBEEF to 0x0000_0010 with `be`=4'b0011, then `dm` read of 0x10 on the next cycle. Required:
  - write cycle: `sram_bweb`=32'hFFFF_0000;
  - read cycle: `sram_a`=4;
  - one cycle later: `dm_rvalid`=1 and `dm_rdata[15:0]`=16'hBEEF.
- `im_req` and `dm_req` held high continuously → grant pattern `dm,dm,dm,dm,im`, repeating; `im_rvalid` pulses every 5th cycle, +1.
- `dm_addr`=0x0001_0000 read → `dm_gnt`=1 and `sram_ceb`=1; next cycle `dm_err`=1, `dm_rvalid`=1, `dm_rdata`=0; `im` traffic is unaffected.
- `im` read of 0x8 granted, then `rst` pulsed low before the next edge → no `im_rvalid` after release and `starve_cnt`=0.
- Back-to-back `im` reads of 0x0, 0x4, 0x8 with no `dm` traffic → three consecutive grants; `im_rvalid` high for 3 cycles with data matching a preloaded memory.
